fft_operand_buffer: RTL and testbench

//  Serial-to-parallel operand buffer directly downstream of the load mux.
//  - Accepts one 16-bit word per cycle: 4 sample words, then twiddle real, then twiddle imag.
//  - Presents all six words in parallel to the butterfly.
//  - Owns and drives samples_loaded_count, which selects the load mux input.

---
 rtl/fft_operand_buffer.sv | 125 ++++++++++++
 tb/tb_fft_operand_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fft_operand_buffer.sv
// Serial-to-parallel operand buffer: collects 4 sample words and 2 twiddle words,
// then holds all six for the butterfly. Optional sticky overflow flag: FFT_OPERAND_BUF_OVERFLOW_EN.
module fft_operand_buffer #(
    parameter int DATA_W  = 16,
    parameter int N_WORDS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              in_ready,
    output logic [2:0]        samples_loaded_count,
    input  logic              flush,
    input  logic              consume,
    output logic              buffer_full,
    output logic [DATA_W-1:0] a_real,
    output logic [DATA_W-1:0] a_imag,
    output logic [DATA_W-1:0] b_real,
    output logic [DATA_W-1:0] b_imag,
    output logic [DATA_W-1:0] tw_real,
    output logic [DATA_W-1:0] tw_imag,
    output logic              overflow_err
);

    localparam logic [2:0] LAST_IDX = 3'(N_WORDS - 1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       load_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // flush outranks consume, which outranks data_valid
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_en = 1'b0;
        if (flush) begin
            state_d = ST_LOAD;
            count_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (data_valid) begin
                        load_en = 1'b1;
                        count_d = count_q + 3'd1;
                        if (count_q == LAST_IDX) begin
                            state_d = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_d = ST_LOAD;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                    count_d = '0;
                end
            endcase
        end
    end

    // Operand words keep their last value across consume and flush
    genvar gi;
    generate
        for (gi = 0; gi < N_WORDS; gi++) begin : gen_word
            logic [DATA_W-1:0] word_q;
            logic              we;

            assign we = load_en && (count_q == 3'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_q <= '0;
                end else if (we) begin
                    word_q <= data_in;
                end
            end
        end
    endgenerate

    assign a_real  = gen_word[0].word_q;
    assign a_imag  = gen_word[1].word_q;
    assign b_real  = gen_word[2].word_q;
    assign b_imag  = gen_word[3].word_q;
    assign tw_real = gen_word[4].word_q;
    assign tw_imag = gen_word[5].word_q;

    assign buffer_full          = (state_q == ST_FULL);
    assign in_ready             = ~buffer_full;
    assign samples_loaded_count = count_q;

`ifdef FFT_OPERAND_BUF_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if ((state_q == ST_FULL) && data_valid && !flush && !consume) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_err = overflow_q;
`else
    assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_operand_buffer.sv
// Directed and randomized checks of fft_operand_buffer against a queue-based model
// of the operand set being assembled.
module tb_fft_operand_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        flush = 1'b0;
    logic        consume = 1'b0;
    logic        in_ready;
    logic [2:0]  samples_loaded_count;
    logic        buffer_full;
    logic [15:0] a_real, a_imag, b_real, b_imag, tw_real, tw_imag;
    logic        overflow_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: words of the set in progress, plus the last value written to each slot
    logic [15:0] set_q[$];
    logic [15:0] held[6];
    bit          ovf_m;

    fft_operand_buffer #(.DATA_W(16), .N_WORDS(6)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_in             (data_in),
        .data_valid          (data_valid),
        .in_ready            (in_ready),
        .samples_loaded_count(samples_loaded_count),
        .flush               (flush),
        .consume             (consume),
        .buffer_full         (buffer_full),
        .a_real              (a_real),
        .a_imag              (a_imag),
        .b_real              (b_real),
        .b_imag              (b_imag),
        .tw_real             (tw_real),
        .tw_imag             (tw_imag),
        .overflow_err        (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        bit full_m;
        full_m = (set_q.size() == 6);
        chk({tag, ".count"},   32'(samples_loaded_count), 32'(set_q.size()));
        chk({tag, ".full"},    32'(buffer_full),  32'(full_m));
        chk({tag, ".ready"},   32'(in_ready),     32'(!full_m));
        chk({tag, ".a_real"},  32'(a_real),       32'(held[0]));
        chk({tag, ".a_imag"},  32'(a_imag),       32'(held[1]));
        chk({tag, ".b_real"},  32'(b_real),       32'(held[2]));
        chk({tag, ".b_imag"},  32'(b_imag),       32'(held[3]));
        chk({tag, ".tw_real"}, 32'(tw_real),      32'(held[4]));
        chk({tag, ".tw_imag"}, 32'(tw_imag),      32'(held[5]));
        chk({tag, ".ovf"},     32'(overflow_err), 32'(ovf_m));
        $display("txn %s: count=%0d full=%0b a_real=%h tw_imag=%h ovf=%0b",
                 tag, samples_loaded_count, buffer_full, a_real, tw_imag, overflow_err);
    endtask

    // Reset takes effect immediately, before any clock edge
    task automatic do_reset(string tag);
        rst = 1'b1;
        #1;
        set_q.delete();
        foreach (held[i]) held[i] = '0;
        ovf_m = 1'b0;
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(bit dv, logic [15:0] d, bit fl, bit cs, string tag);
        data_valid = dv;
        data_in    = d;
        flush      = fl;
        consume    = cs;
        if (fl) begin
            set_q.delete();
        end else if (set_q.size() == 6) begin
            if (cs) set_q.delete();
`ifdef FFT_OPERAND_BUF_OVERFLOW_EN
            else if (dv) ovf_m = 1'b1;
`endif
        end else if (dv) begin
            held[set_q.size()] = d;
            set_q.push_back(d);
        end
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        flush      = 1'b0;
        consume    = 1'b0;
        check_all(tag);
    endtask

    initial begin
        do_reset("reset");

        // 1: six words fill the set
        for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'b0, 1'b0, $sformatf("t1.w%0d", i));
        chk("t1.a_real_is_1", 32'(a_real), 32'h1);
        chk("t1.tw_imag_is_6", 32'(tw_imag), 32'h6);

        // 2: consume empties the set, operands hold
        step(1'b0, 16'h0, 1'b0, 1'b1, "t2.consume");
        step(1'b0, 16'h0, 1'b0, 1'b0, "t2.idle");

        // 3: partial set then flush with a valid word
        for (int i = 0; i < 3; i++) step(1'b1, 16'hAAAA, 1'b0, 1'b0, $sformatf("t3.w%0d", i));
        step(1'b1, 16'hBBBB, 1'b1, 1'b0, "t3.flush");
        step(1'b0, 16'h0, 1'b0, 1'b1, "t3.consume_in_load");
        for (int i = 0; i < 6; i++) step(1'b1, 16'h100 + 16'(i), 1'b0, 1'b0, $sformatf("t3.r%0d", i));
        chk("t3.a_real_new", 32'(a_real), 32'h100);

        // 4: consume beats data_valid when full
        step(1'b1, 16'h1234, 1'b0, 1'b1, "t4.consume_dv");
        chk("t4.a_real_kept", 32'(a_real), 32'h100);

        // 5: alternating valid
        for (int i = 0; i < 12; i++)
            step(1'((i % 2) == 0), 16'h200 + 16'(i), 1'b0, 1'b0, $sformatf("t5.c%0d", i));

        // 6: valid while full without consume, then consume, then flush
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, "t6.dv_full");
        step(1'b0, 16'h0, 1'b0, 1'b1, "t6.consume");
        step(1'b0, 16'h0, 1'b1, 1'b0, "t6.flush");
`ifdef FFT_OPERAND_BUF_OVERFLOW_EN
        chk("t6.ovf_sticky", 32'(overflow_err), 32'h1);
`else
        chk("t6.ovf_tied", 32'(overflow_err), 32'h0);
`endif

        // Reset in the middle of a set
        for (int i = 0; i < 4; i++) step(1'b1, 16'h300 + 16'(i), 1'b0, 1'b0, $sformatf("mid.w%0d", i));
        do_reset("mid.reset");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit fl, cs, dv;
            fl = ($urandom_range(99) < 4);
            cs = ($urandom_range(99) < 25);
            dv = ($urandom_range(99) < 70);
            step(dv, 16'($urandom), fl, cs, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
